// File: rtl/arb_rr8_pkg.sv
// arb_rr8_pkg: shared definitions for the 8-way round-robin arbiter.
//   NUM_REQ          number of requesters (8)
//   SEL_W            width of the binary owner index (3)
//   MAX_HOLD_DEFAULT default hold limit used when ARB_TIMEOUT_EN is defined
//   arb_state_e      arbiter FSM encoding (StIdle = 0, StBusy = 1)
//   sel_to_onehot    binary owner index -> one-hot grant vector
package arb_rr8_pkg;

    localparam int unsigned NUM_REQ          = 8;
    localparam int unsigned SEL_W            = 3;
    localparam int unsigned MAX_HOLD_DEFAULT = 16;

    typedef enum logic {
        StIdle = 1'b0,
        StBusy = 1'b1
    } arb_state_e;

    function automatic logic [NUM_REQ-1:0] sel_to_onehot(input logic [SEL_W-1:0] s);
        logic [NUM_REQ-1:0] one;
        one = {{(NUM_REQ - 1){1'b0}}, 1'b1};
        return one << s;
    endfunction

endpackage

// File: rtl/arb_rr8_if.sv
// arb_rr8_if: request/grant bundle between the requesters and the arbiter.
//   req      requester -> arbiter, one bit per requester, level-held
//   done     owner -> arbiter, last cycle of use
//   grant    arbiter -> requesters, one-hot owner, zero when idle
//   sel      arbiter -> datapath mux, binary owner index (holds last owner)
//   busy     arbiter -> requesters, grant active
//   timeout  arbiter -> requesters, pulse on forced release
// Modports: master = requester side, slave = arbiter side.
interface arb_rr8_if;
    import arb_rr8_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic               done;
    logic [NUM_REQ-1:0] grant;
    logic [SEL_W-1:0]   sel;
    logic               busy;
    logic               timeout;

    modport master (
        output req,
        output done,
        input  grant,
        input  sel,
        input  busy,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output grant,
        output sel,
        output busy,
        output timeout
    );

endinterface

// File: rtl/arb_rr8_pick.sv
// rr_pick8: combinational rotating-priority picker.
//   req  request vector
//   ptr  highest-priority index for this pick
//   any  at least one request set
//   idx  first set request scanning ptr, ptr+1, ..., 7, 0, ..., ptr-1
module rr_pick8
    import arb_rr8_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               any,
    output logic [SEL_W-1:0]   idx
);

    logic [SEL_W-1:0] cand;

    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // 3-bit add wraps naturally past requester 7
            cand = ptr + SEL_W'(k);
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/arb_rr8.sv
// arb_rr8: round-robin arbiter granting one of eight requesters a shared
// 32-bit datapath resource. Grant is held until the owner signals done or
// withdraws its request; every release inserts one idle cycle and rotates
// priority to the requester after the last owner.
//   clock  rising-edge clock
//   reset  asynchronous, active-low
//   bus    arb_rr8_if.slave (req, done in; grant, sel, busy, timeout out)
// Optional feature: define ARB_TIMEOUT_EN to force release after MAX_HOLD
// busy cycles (legal 2..256); otherwise timeout is tied to 0.
module arb_rr8
    import arb_rr8_pkg::*;
#(
    parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input logic       clock,
    input logic       reset,
    arb_rr8_if.slave  bus
);

    arb_state_e         state_q;
    logic [SEL_W-1:0]   ptr_q;
    logic [SEL_W-1:0]   sel_q;
    logic [NUM_REQ-1:0] grant_q;
    logic               busy_q;

    logic               pick_any;
    logic [SEL_W-1:0]   pick_idx;
    logic               force_rel;
    logic               release_now;

    rr_pick8 u_pick (
        .req (bus.req),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CntW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    logic [CntW-1:0] cnt_q;

    // Held at zero while idle so the first busy cycle counts as 0.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (state_q == StIdle) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // A done on the last allowed cycle is a normal release, not a timeout.
    assign force_rel = (state_q == StBusy) && (cnt_q == CntW'(MAX_HOLD - 1)) && !bus.done;
`else
    logic unused_max_hold;

    assign unused_max_hold = ^MAX_HOLD;
    assign force_rel       = 1'b0;
`endif

    assign release_now = bus.done || !bus.req[sel_q] || force_rel;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            sel_q   <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pick_any) begin
                        state_q <= StBusy;
                        sel_q   <= pick_idx;
                        grant_q <= sel_to_onehot(pick_idx);
                        busy_q  <= 1'b1;
                        ptr_q   <= pick_idx + 1'b1;
                    end
                end
                StBusy: begin
                    // sel keeps the last owner so the mux stays stable while idle
                    if (release_now) begin
                        state_q <= StIdle;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant   = grant_q;
    assign bus.sel     = sel_q;
    assign bus.busy    = busy_q;
    assign bus.timeout = force_rel;

endmodule
